// File: rtl/debounce_enable_latch_pkg.sv
// Shared types for the push-button debounce / enable-latch block:
// debouncer FSM encoding and the press-counter width.
package debounce_enable_latch_pkg;

    localparam int unsigned PressCountWidth = 8;

    typedef enum logic [1:0] {
        StStableLow  = 2'd0,
        StCheckHigh  = 2'd1,
        StStableHigh = 2'd2,
        StCheckLow   = 2'd3
    } state_e;

endpackage

// File: rtl/debounce_enable_latch_sync_chain.sv
// Multi-flop synchroniser for an asynchronous level input; synchronous
// active-high reset clears every stage. Reusable for other board inputs.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_Async};
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_Sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_enable_latch.sv
// Synchronise + debounce a push button; each accepted press strobes, toggles
// a latched enable and bumps a press counter. DEBOUNCE_ENABLE_ACTIVE_LOW_EN
// selects an active-low button.
module debounce_enable_latch
    import debounce_enable_latch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic                       i_Switch,
    output logic                       o_Debounced,
    output logic                       o_Press_Pulse,
    output logic                       o_Enable,
    output logic [PressCountWidth-1:0] o_Press_Count
);

    localparam int unsigned    CntW    = $clog2(DEBOUNCE_LIMIT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_LIMIT - 1);

    logic switch_level;
    logic sync;

`ifdef DEBOUNCE_ENABLE_ACTIVE_LOW_EN
    // Inverted so that a reset synchroniser (all zeros) means "released".
    assign switch_level = ~i_Switch;
`else
    assign switch_level = i_Switch;
`endif

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_chain (
        .i_Clk  (i_Clk),
        .i_Reset(i_Reset),
        .i_Async(switch_level),
        .o_Sync (sync)
    );

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                debounced_q, debounced_d;
    logic                pulse_q, pulse_d;
    logic                enable_q, enable_d;
    logic [PressCountWidth-1:0] count_q, count_d;

    // State register (counter travels with the state).
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= StStableLow;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StStableLow: begin
                if (sync) begin
                    state_d = StCheckHigh;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StCheckHigh: begin
                if (!sync) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStableHigh: begin
                if (!sync) begin
                    state_d = StCheckLow;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StCheckLow: begin
                if (sync) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StStableLow;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs. Only a press
    // commit strobes, toggles and counts; a release commit just drops the level.
    always_comb begin
        debounced_d = debounced_q;
        pulse_d     = 1'b0;
        enable_d    = enable_q;
        count_d     = count_q;
        unique case (state_q)
            StCheckHigh: begin
                if (sync && (cnt_q == CntLast)) begin
                    debounced_d = 1'b1;
                    pulse_d     = 1'b1;
                    enable_d    = ~enable_q;
                    count_d     = count_q + PressCountWidth'(1);
                end
            end
            StCheckLow: begin
                if (!sync && (cnt_q == CntLast)) begin
                    debounced_d = 1'b0;
                end
            end
            default: begin
                debounced_d = debounced_q;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            debounced_q <= 1'b0;
            pulse_q     <= 1'b0;
            enable_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            debounced_q <= debounced_d;
            pulse_q     <= pulse_d;
            enable_q    <= enable_d;
            count_q     <= count_d;
        end
    end

    assign o_Debounced   = debounced_q;
    assign o_Press_Pulse = pulse_q;
    assign o_Enable      = enable_q;
    assign o_Press_Count = count_q;

endmodule

// File: doc/debounce_enable_latch.md
Name: debounce_enable_latch

Overview:
- Upstream conditioning stage for the count-and-toggle blinker.
- Takes a raw, bouncing push-button input, synchronises it to i_Clk and debounces it.
- Each debounced press flips a latched enable level. That level drives the blinker's enable input directly: press once to start blinking, press again to stop and clear.
- Also exposes a one-cycle press strobe and an 8-bit press counter for status LEDs and 7-segment displays.

Parameters:
- DEBOUNCE_LIMIT, 250000, consecutive cycles the synchronised input must hold a new level before it is accepted (10 ms at 25 MHz); legal range ≥2.
- SYNC_STAGES, 2, flip-flops in the input synchroniser chain; legal range ≥2.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Switch  input  1  raw asynchronous push-button level (pressed = 1).
- o_Debounced  output  1  debounced, synchronised switch level.
- o_Press_Pulse  output  1  one-cycle strobe on each accepted press (low→high commit).
- o_Enable  output  1  latched enable; toggles on each accepted press.
- o_Press_Count  output  8  number of accepted presses, wraps modulo 256.

Behaviour:
- Reset (i_Reset sampled high at an edge):
  - Synchroniser chain, debounce counter, FSM (STABLE_LOW) and all outputs go to 0 at that edge.
  - Reset takes priority over every other event.
  - Reset mid-debounce discards the partial count.
- Synchroniser: i_Switch shifts through SYNC_STAGES flops. Only the last stage ("sync") is used by the FSM.
- Debounce counter: width $clog2(DEBOUNCE_LIMIT)+1 bits, unsigned; never wraps, because it is cleared on every commit or abort.
- FSM states and transitions (evaluated each edge when not in reset):
  - STABLE_LOW: if sync=1, go to CHECK_HIGH with counter←1; else stay, counter←0.
  - CHECK_HIGH:
    - sync=0: abort to STABLE_LOW, counter←0.
    - sync=1 and counter==DEBOUNCE_LIMIT-1: commit to STABLE_HIGH, counter←0, o_Debounced←1, o_Press_Pulse←1, o_Enable←!o_Enable, o_Press_Count←o_Press_Count+1.
    - Otherwise: counter+1.
  - STABLE_HIGH: if sync=0, go to CHECK_LOW with counter←1; else stay.
  - CHECK_LOW:
    - sync=1: abort to STABLE_HIGH, counter←0.
    - sync=0 and counter==DEBOUNCE_LIMIT-1: commit to STABLE_LOW, counter←0, o_Debounced←0.
    - Otherwise: counter+1.
    - A release commit produces no pulse and no toggle.
- Latency: if i_Switch is first sampled high at edge k and stays high, o_Debounced, o_Press_Pulse and the o_Enable toggle all appear after edge k+SYNC_STAGES+DEBOUNCE_LIMIT-1. Release follows the same latency.
- o_Press_Pulse: high for exactly one cycle, then 0 the next cycle unconditionally; it is never high on two consecutive cycles.
- Glitches shorter than DEBOUNCE_LIMIT synchronised cycles are ignored entirely.
- A switch held high across reset release is debounced normally and counts as one press.
- o_Press_Count wraps 255→0 on the 256th press; o_Enable toggles regardless.
- All outputs are registered; there are no combinational paths from i_Switch.

Optional Feature:
- Macro DEBOUNCE_ENABLE_ACTIVE_LOW_EN.
- Defined: i_Switch is inverted before the first synchroniser stage (pressed = 0). Synchroniser flops still reset to 0, which is the released state after inversion. All other behaviour is unchanged.
- Undefined: i_Switch is active-high exactly as described above.

Decomposition:
- Shared package holds the FSM state encoding (2-bit: STABLE_LOW=0, CHECK_HIGH=1, STABLE_HIGH=2, CHECK_LOW=3) and the press-count width constant (8).
- One natural sub-module: sync_chain (parameter SYNC_STAGES; ports i_Clk, i_Reset, i_Async, o_Sync). It is reusable for other board inputs.

Test Plan (DEBOUNCE_LIMIT=4, SYNC_STAGES=2 unless noted):
- Reset: assert i_Reset 2 cycles with i_Switch=1 → all outputs 0 at the edge after assertion. Release reset → o_Enable=1 and o_Press_Count=1 exactly 5 edges later.
- Clean press: i_Switch 0→1 at edge 10, held 20 cycles → o_Press_Pulse high only after edge 15, o_Enable 0→1, o_Debounced 1. Release at edge 30 → o_Debounced 0 after edge 35, with no pulse and o_Enable still 1.
- Bounce: i_Switch pattern 1,0,1,1,0,1 then steady 1 → exactly one pulse, o_Press_Count=1, pulse 5 edges after the last 0→1 transition.
- Short glitch: i_Switch high for 3 cycles then low → no pulse, o_Debounced stays 0, o_Enable unchanged.
- Wrap and toggle: 256 clean presses → o_Press_Count returns to 0 and o_Enable ends at 0. Assert reset mid-CHECK_HIGH on press 257 → no pulse, all outputs 0.
- Macro build with DEBOUNCE_ENABLE_ACTIVE_LOW_EN: hold i_Switch=1 → no activity. Drive i_Switch 1→0 held 10 cycles → one pulse, o_Enable=1.
